// File: rtl/nibble_serial_add_ctrl.sv
// Sequences a WIDTH-bit add/subtract through one external 4-bit adder slice, LSB nibble first.
// Optional NSADD_ZERO_BYPASS_EN: trivial operands skip the nibble loop and complete one edge after accept.
module nibble_serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             op_i,
  input  logic             ci_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_ci,
  input  logic [3:0]       add_s,
  input  logic             add_co
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned SW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [SW-1:0]    step;
  logic [SW+1:0]    nib_idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg, sum_nxt;
  logic             accept, last, bypass;
  logic [WIDTH-1:0] byp_sum;
  logic             byp_cout;

  assign nib_idx = {step, 2'b00};
  assign last    = (step == SW'(NIB - 1));
  assign accept  = in_valid & in_ready;

`ifdef NSADD_ZERO_BYPASS_EN
  // Operands whose result needs no carry propagation are resolved at accept
  always_comb begin
    bypass   = 1'b0;
    byp_sum  = a_i | b_i;
    byp_cout = 1'b0;
    if (op_i) begin
      if (b_i == '0) begin
        bypass   = 1'b1;
        byp_sum  = a_i;
        byp_cout = 1'b1;
      end
    end else if (!ci_i && ((a_i == '0) || (b_i == '0))) begin
      bypass = 1'b1;
    end
  end
`else
  assign bypass   = 1'b0;
  assign byp_sum  = '0;
  assign byp_cout = 1'b0;
`endif

  // Running sum with the current slice result merged into its nibble
  always_comb begin
    sum_nxt              = sum_reg;
    sum_nxt[nib_idx +: 4] = add_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = bypass ? DONE : RUN;
      end
      RUN: begin
        add_a  = a_reg[nib_idx +: 4];
        add_b  = b_reg[nib_idx +: 4];
        add_ci = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) state_nxt = bypass ? DONE : RUN;
          else          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status flags follow the next state so they are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      busy_o    <= (state_nxt != IDLE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      carry   <= 1'b0;
      step    <= '0;
      sum_o   <= '0;
      cout_o  <= 1'b0;
    end else if (accept) begin
      a_reg <= a_i;
      b_reg <= op_i ? ~b_i : b_i;
      carry <= op_i | ci_i;
      step  <= '0;
      if (bypass) begin
        sum_o  <= byp_sum;
        cout_o <= byp_cout;
      end
    end else if (state == RUN) begin
      sum_reg <= sum_nxt;
      carry   <= add_co;
      step    <= step + SW'(1);
      if (last) begin
        sum_o  <= sum_nxt;
        cout_o <= add_co;
      end
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl with a behavioural 4-bit adder slice.
// Expected latency for trivial operands follows NSADD_ZERO_BYPASS_EN.
module tb_nibble_serial_add_ctrl;

  localparam int W        = 16;
  localparam int LAT_FULL = 5;
`ifdef NSADD_ZERO_BYPASS_EN
  localparam int LAT_BYP  = 1;
`else
  localparam int LAT_BYP  = 5;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         op_i;
  logic         ci_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_o;
  logic         cout_o;
  logic         busy_o;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_ci;
  logic [3:0]   add_s;
  logic         add_co;

  int checks;
  int errors;

  nibble_serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_i(a_i), .b_i(b_i), .op_i(op_i), .ci_i(ci_i),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_o(sum_o), .cout_o(cout_o), .busy_o(busy_o),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co)
  );

  // External carry-lookahead slice modelled behaviourally
  assign {add_co, add_s} = 5'(add_a) + 5'(add_b) + 5'(add_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for out_valid; records slice inputs per RUN step
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                       input logic ci, input logic ack, output logic rdy,
                       output int lat, output logic [15:0] aseq, output logic [15:0] bseq,
                       output logic [3:0] ciseq);
    aseq  = '0;
    bseq  = '0;
    ciseq = '0;
    @(negedge clk);
    a_i = a; b_i = b; op_i = op; ci_i = ci; in_valid = 1'b1;
    if (ack) out_ready = 1'b1;
    #1 rdy = in_ready;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    a_i = ~a; b_i = ~b; op_i = ~op; ci_i = ~ci;
    lat = 1;
    while (!out_valid && lat < 20) begin
      aseq  = {add_a, aseq[15:4]};
      bseq  = {add_b, bseq[15:4]};
      ciseq = {add_ci, ciseq[3:1]};
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy_o, cout_o} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/busy/cout=%b required 1000",
               {in_ready, out_valid, busy_o, cout_o});
    end
    checks++;
    if ({sum_o, add_a, add_b, add_ci} !== 25'd0) begin
      errors++;
      $display("FAIL reset_data: got sum=%h a=%h b=%h ci=%b required all zero",
               sum_o, add_a, add_b, add_ci);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_basic();
    logic rdy; int lat; logic [15:0] as, bs; logic [3:0] cs;
    do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL add_basic_ready: got %b required 1", rdy); end
    checks++;
    if (lat != LAT_FULL) begin errors++; $display("FAIL add_basic_latency: got %0d required %0d", lat, LAT_FULL); end
    checks++;
    if (as !== 16'h1234) begin errors++; $display("FAIL add_basic_a_seq: got %h required 1234", as); end
    checks++;
    if (bs !== 16'h0FFF) begin errors++; $display("FAIL add_basic_b_seq: got %h required 0fff", bs); end
    checks++;
    if ({sum_o, cout_o} !== {16'h2233, 1'b0}) begin
      errors++; $display("FAIL add_basic_result: got sum=%h cout=%b required 2233/0", sum_o, cout_o);
    end
    checks++;
    if ({busy_o, in_ready} !== 2'b10) begin
      errors++; $display("FAIL add_basic_done_flags: got busy/rdy=%b required 10", {busy_o, in_ready});
    end
    release_result();
    checks++;
    if ({out_valid, busy_o, in_ready, sum_o} !== {3'b001, 16'h2233}) begin
      errors++; $display("FAIL add_basic_after_hs: got vld/busy/rdy=%b sum=%h required 001/2233",
                         {out_valid, busy_o, in_ready}, sum_o);
    end
  endtask

  task automatic test_add_carry_ripple();
    logic rdy; int lat; logic [15:0] as, bs; logic [3:0] cs;
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if (cs !== 4'b1110) begin errors++; $display("FAIL ripple_ci_seq: got %b required 1110 (lsb first)", cs); end
    checks++;
    if ({sum_o, cout_o} !== {16'h0000, 1'b1} || lat != LAT_FULL) begin
      errors++; $display("FAIL ripple_result: got sum=%h cout=%b lat=%0d required 0000/1/%0d",
                         sum_o, cout_o, lat, LAT_FULL);
    end
    release_result();
    do_op(16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if ({sum_o, cout_o} !== {16'h0100, 1'b0} || lat != LAT_FULL) begin
      errors++; $display("FAIL add_ci_result: got sum=%h cout=%b lat=%0d required 0100/0/%0d",
                         sum_o, cout_o, lat, LAT_FULL);
    end
    release_result();
  endtask

  task automatic test_sub();
    logic rdy; int lat; logic [15:0] as, bs; logic [3:0] cs;
    do_op(16'h0005, 16'h0007, 1'b1, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if (bs !== 16'hFFF8 || cs[0] !== 1'b1) begin
      errors++; $display("FAIL sub_inverted_b: got b_seq=%h ci0=%b required fff8/1", bs, cs[0]);
    end
    checks++;
    if ({sum_o, cout_o} !== {16'hFFFE, 1'b0}) begin
      errors++; $display("FAIL sub_borrow: got sum=%h cout=%b required fffe/0", sum_o, cout_o);
    end
    release_result();
    do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if ({sum_o, cout_o} !== {16'h0002, 1'b1}) begin
      errors++; $display("FAIL sub_no_borrow: got sum=%h cout=%b required 0002/1", sum_o, cout_o);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    logic rdy; int lat; logic [15:0] as, bs; logic [3:0] cs;
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({out_valid, in_ready, sum_o, cout_o} !== {2'b10, 16'h3333, 1'b0}) begin
        errors++; $display("FAIL backpressure_hold[%0d]: got vld/rdy=%b sum=%h cout=%b required 10/3333/0",
                           i, {out_valid, in_ready}, sum_o, cout_o);
      end
      @(negedge clk);
    end
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, rdy, lat, as, bs, cs);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b required 1", rdy); end
    checks++;
    if (lat != LAT_FULL) begin errors++; $display("FAIL b2b_latency: got %0d required %0d", lat, LAT_FULL); end
    checks++;
    if ({sum_o, cout_o} !== {16'h0000, 1'b1}) begin
      errors++; $display("FAIL b2b_result: got sum=%h cout=%b required 0000/1", sum_o, cout_o);
    end
    release_result();
  endtask

  task automatic test_reset_mid_run();
    logic spurious;
    @(negedge clk);
    a_i = 16'h5555; b_i = 16'h1111; op_i = 1'b0; ci_i = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_o, add_a} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL midrun_step2: got busy=%b add_a=%h required 1/5", busy_o, add_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy_o, cout_o, add_ci} !== 5'b10000 || {sum_o, add_a, add_b} !== 24'd0) begin
      errors++; $display("FAIL midrun_reset: got rdy/vld/busy/cout/ci=%b sum=%h a=%h b=%h required 10000/0/0/0",
                         {in_ready, out_valid, busy_o, cout_o, add_ci}, sum_o, add_a, add_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious = 1'b1;
    end
    checks++;
    if (spurious !== 1'b0) begin
      errors++; $display("FAIL midrun_no_spurious: got flag=%b required 0", spurious);
    end
  endtask

  task automatic test_zero_operand();
    logic rdy; int lat; logic [15:0] as, bs; logic [3:0] cs;
    do_op(16'h0000, 16'h00AB, 1'b0, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if ({sum_o, cout_o} !== {16'h00AB, 1'b0} || lat != LAT_BYP) begin
      errors++; $display("FAIL zero_add: got sum=%h cout=%b lat=%0d required 00ab/0/%0d",
                         sum_o, cout_o, lat, LAT_BYP);
    end
    release_result();
    do_op(16'h1234, 16'h0000, 1'b1, 1'b0, 1'b0, rdy, lat, as, bs, cs);
    checks++;
    if ({sum_o, cout_o} !== {16'h1234, 1'b1} || lat != LAT_BYP) begin
      errors++; $display("FAIL zero_sub: got sum=%h cout=%b lat=%0d required 1234/1/%0d",
                         sum_o, cout_o, lat, LAT_BYP);
    end
    release_result();
    checks++;
    if ({out_valid, in_ready, busy_o} !== 3'b010) begin
      errors++; $display("FAIL zero_idle: got vld/rdy/busy=%b required 010", {out_valid, in_ready, busy_o});
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; op_i = 1'b0; ci_i = 1'b0;
    test_reset();
    test_add_basic();
    test_add_carry_ripple();
    test_sub();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_operand();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
